// File: rtl/mem_arbiter.sv
// Two-port arbiter (instruction fetch vs. data) in front of one single-port memory.
// Define MEM_ARBITER_RR_EN for round-robin; otherwise data has priority, bounded by a starve counter.
module mem_arbiter #(
  parameter int STARVE_MAX     = 4,
  parameter int MEM_WORDS_LOG2 = 11
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        d_err,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam logic [31:0] NOP_INSN = 32'h0000_0013;

  logic w_if_gnt;
  logic w_d_gnt;
  logic w_if_oor;
  logic w_d_oor;

  logic        r_if_rvalid;
  logic [31:0] r_if_rdata;
  logic        r_d_rvalid;
  logic [31:0] r_d_rdata;
  logic        r_d_err;

  // Byte address: word index occupies bits [MEM_WORDS_LOG2+1:2]; anything above is outside the memory.
  assign w_if_oor = |if_addr[31:MEM_WORDS_LOG2+2];
  assign w_d_oor  = |d_addr[31:MEM_WORDS_LOG2+2];

`ifdef MEM_ARBITER_RR_EN
  logic r_last_d;

  always_comb begin
    w_d_gnt  = !rst && d_req && !(if_req && r_last_d);
    w_if_gnt = !rst && if_req && !w_d_gnt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last_d <= 1'b0;
    end else if (w_d_gnt) begin
      r_last_d <= 1'b1;
    end else if (w_if_gnt) begin
      r_last_d <= 1'b0;
    end
  end
`else
  logic [3:0] r_starve;
  logic       w_fetch_turn;

  assign w_fetch_turn = (r_starve == 4'(STARVE_MAX));

  always_comb begin
    w_d_gnt  = !rst && d_req && !(if_req && w_fetch_turn);
    w_if_gnt = !rst && if_req && !w_d_gnt;
  end

  // Counts data grants taken while fetch waits; saturates so fetch keeps its turn.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_starve <= 4'd0;
    end else if (!if_req || w_if_gnt) begin
      r_starve <= 4'd0;
    end else if (w_d_gnt && !w_fetch_turn) begin
      r_starve <= r_starve + 4'd1;
    end
  end
`endif

  assign if_gnt = w_if_gnt;
  assign d_gnt  = w_d_gnt;

  always_comb begin
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_addr  = 32'd0;
    mem_wdata = 32'd0;
    if (w_if_gnt) begin
      mem_addr = if_addr;
      mem_read = !w_if_oor;
    end else if (w_d_gnt) begin
      mem_addr  = d_addr;
      mem_wdata = d_wdata;
      mem_write = d_we && !w_d_oor;
      mem_read  = !d_we && !w_d_oor;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_if_rvalid <= 1'b0;
      r_if_rdata  <= 32'd0;
      r_d_rvalid  <= 1'b0;
      r_d_rdata   <= 32'd0;
      r_d_err     <= 1'b0;
    end else begin
      r_if_rvalid <= w_if_gnt;
      r_d_rvalid  <= w_d_gnt;
      r_d_err     <= w_d_gnt && w_d_oor;
      r_if_rdata  <= 32'd0;
      r_d_rdata   <= 32'd0;
      if (w_if_gnt) begin
        r_if_rdata <= w_if_oor ? NOP_INSN : mem_rdata;
      end
      if (w_d_gnt && !d_we && !w_d_oor) begin
        r_d_rdata <= mem_rdata;
      end
    end
  end

  assign if_rvalid = r_if_rvalid;
  assign if_rdata  = r_if_rdata;
  assign d_rvalid  = r_d_rvalid;
  assign d_rdata   = r_d_rdata;
  assign d_err     = r_d_err;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: grant/memory-side checks inline, responses via a scoreboard queue.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, d_req, d_we;
  logic [31:0] if_addr, d_addr, d_wdata, mem_rdata;
  logic        if_gnt, if_rvalid, d_gnt, d_rvalid, d_err;
  logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;
  logic        mem_read, mem_write;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic        is_d;
    logic [31:0] rdata;
    logic        err;
  } resp_t;

  resp_t exp_q[$];

  mem_arbiter #(.STARVE_MAX(4), .MEM_WORDS_LOG2(11)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // One cycle: drive inputs, check grant and memory side mid-cycle, queue the expected response.
  task automatic step(input string name,
                      input logic ifr, input logic [31:0] ifa,
                      input logic dr, input logic dwe, input logic [31:0] da,
                      input logic [31:0] dwd, input logic [31:0] rd,
                      input logic eig, input logic edg, input logic emr, input logic emw,
                      input logic [31:0] ema, input logic [31:0] erd, input logic eerr,
                      input logic push);
    resp_t r;
    @(posedge clk);
    #1;
    if_req = ifr; if_addr = ifa; d_req = dr; d_we = dwe; d_addr = da; d_wdata = dwd;
    mem_rdata = rd;
    #3;
    chk({name, "_if_gnt"}, 32'(if_gnt), 32'(eig));
    chk({name, "_d_gnt"}, 32'(d_gnt), 32'(edg));
    chk({name, "_mem_read"}, 32'(mem_read), 32'(emr));
    chk({name, "_mem_write"}, 32'(mem_write), 32'(emw));
    chk({name, "_mem_addr"}, mem_addr, ema);
    chk({name, "_mem_wdata"}, mem_wdata, edg ? dwd : 32'd0);
    $display("step %s: if_gnt=%0b d_gnt=%0b mem_addr=0x%08h", name, if_gnt, d_gnt, mem_addr);
    if (push && (eig || edg)) begin
      r.is_d = edg; r.rdata = erd; r.err = eerr;
      exp_q.push_back(r);
    end
  endtask

  task automatic idle(input string name);
    step(name, 0, 0, 0, 0, 0, 0, 32'hFFFF_FFFF, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic reset_pulse();
    @(posedge clk);
    #1;
    rst = 1'b1;
    if_req = 0; d_req = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Response monitor: every rvalid must match the oldest queued expectation.
  always @(negedge clk) begin
    if (!rst) begin
      if (if_rvalid && d_rvalid) begin
        errors++; checks++;
        $display("FAIL both_rvalid: if_rvalid=1 d_rvalid=1 expected at most one");
      end else if (if_rvalid || d_rvalid) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_rvalid: if_rvalid=%0b d_rvalid=%0b with nothing expected", if_rvalid, d_rvalid);
        end else begin
          resp_t e;
          e = exp_q.pop_front();
          if (d_rvalid !== e.is_d) begin
            errors++;
            $display("FAIL resp_port: got d_rvalid=%0b expected %0b", d_rvalid, e.is_d);
          end else begin
            chk("resp_rdata", e.is_d ? d_rdata : if_rdata, e.rdata);
            chk("resp_err", 32'(d_err), 32'(e.err));
            $display("resp %s: rdata=0x%08h err=%0b", e.is_d ? "D" : "IF", e.is_d ? d_rdata : if_rdata, d_err);
          end
        end
      end
      if (!if_rvalid) chk("if_rdata_idle", if_rdata, 32'd0);
      if (!d_rvalid) begin
        chk("d_rdata_idle", d_rdata, 32'd0);
        chk("d_err_idle", 32'(d_err), 32'd0);
      end
    end
  end

  logic exp_d_seq [6];

  initial begin
    rst = 1'b1;
    if_req = 1; if_addr = 32'h40; d_req = 1; d_we = 0; d_addr = 32'h100;
    d_wdata = 0; mem_rdata = 32'hDEADBEEF;
    repeat (2) @(posedge clk);
    #3;
    chk("rst_if_gnt", 32'(if_gnt), 0);
    chk("rst_d_gnt", 32'(d_gnt), 0);
    chk("rst_if_rvalid", 32'(if_rvalid), 0);
    chk("rst_d_rvalid", 32'(d_rvalid), 0);
    chk("rst_d_err", 32'(d_err), 0);
    chk("rst_if_rdata", if_rdata, 0);
    chk("rst_d_rdata", d_rdata, 0);
    if_req = 0; d_req = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Test 1: fetch read.
    step("t1_fetch", 1, 32'h40, 0, 0, 0, 0, 32'hDEADBEEF, 1, 0, 1, 0, 32'h40, 32'hDEADBEEF, 0, 1);
    // Test 2: data write returns zero data.
    step("t2_dwrite", 0, 0, 1, 1, 32'h100, 32'h12345678, 32'hAAAA5555, 0, 1, 0, 1, 32'h100, 0, 0, 1);
    // Data read back to back, then highest in-range word address.
    step("dread", 0, 0, 1, 0, 32'h200, 0, 32'hCAFEF00D, 0, 1, 1, 0, 32'h200, 32'hCAFEF00D, 0, 1);
    step("dread_top", 0, 0, 1, 0, 32'h1FFC, 0, 32'h0BADF00D, 0, 1, 1, 0, 32'h1FFC, 32'h0BADF00D, 0, 1);
    idle("idle0");

    // Test 3/4: contention from reset.
    reset_pulse();
`ifdef MEM_ARBITER_RR_EN
    exp_d_seq = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
`else
    exp_d_seq = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
`endif
    for (int i = 0; i < 6; i++) begin
      logic [31:0] rd;
      rd = 32'h1000 + 32'(i);
      if (exp_d_seq[i])
        step($sformatf("contend%0d", i), 1, 32'h80, 1, 0, 32'h300, 0, rd, 0, 1, 1, 0, 32'h300, rd, 0, 1);
      else
        step($sformatf("contend%0d", i), 1, 32'h80, 1, 0, 32'h300, 0, rd, 1, 0, 1, 0, 32'h80, rd, 0, 1);
    end
    idle("idle1");

    // Test 5: out-of-range accesses.
    step("t5_d_oor", 0, 0, 1, 0, 32'h2000, 0, 32'h55AA55AA, 0, 1, 0, 0, 32'h2000, 0, 1, 1);
    step("t5_d_oor_wr", 0, 0, 1, 1, 32'h2004, 32'h77, 32'h55AA55AA, 0, 1, 0, 0, 32'h2004, 0, 1, 1);
    step("t5_if_oor", 1, 32'h4000, 0, 0, 0, 0, 32'h55AA55AA, 1, 0, 0, 0, 32'h4000, 32'h13, 0, 1);
    idle("idle2");

    // Test 6: reset right after a grant cancels the response.
    step("t6_grant", 0, 0, 1, 0, 32'h10, 0, 32'h11112222, 0, 1, 1, 0, 32'h10, 0, 0, 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    d_req = 0; if_req = 0;
    #3;
    chk("t6_d_rvalid_rst", 32'(d_rvalid), 0);
    chk("t6_d_rdata_rst", d_rdata, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle("t6_post0");
    idle("t6_post1");
    chk("t6_d_rvalid_after", 32'(d_rvalid), 0);
    chk("t6_if_rvalid_after", 32'(if_rvalid), 0);
    idle("t6_post2");

    @(posedge clk);
    @(posedge clk);
    #1;
    chk("queue_drained", 32'(exp_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
